// File: rtl/transpose_addr_gen_pkg.sv
// Shared types and elaboration-time stride math for the tiled transpose address generator.
package transpose_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_TRANSPOSE = 1'b0;
   localparam logic MODE_COPY      = 1'b1;

   // Which counter level advances on a beat; the outermost carry wins.
   typedef enum logic [1:0] {
      STEP_C  = 2'd0,
      STEP_R  = 2'd1,
      STEP_TC = 2'd2,
      STEP_TR = 2'd3
   } step_e;

   // Byte delta between consecutive pairs for the given carry level.
   // Row-major (source / copy) or column-major (transpose destination) layout.
   function automatic int stride_bytes(step_e step, bit transpose, int rows, int cols,
                                       int tile, int eb);
      int elems;
      elems = 0;
      if (!transpose) begin
         case (step)
            STEP_C:  elems = 1;
            STEP_R:  elems = cols - (tile - 1);
            STEP_TC: elems = 1 - (tile - 1) * cols;
            default: elems = 1;
         endcase
      end else begin
         case (step)
            STEP_C:  elems = rows;
            STEP_R:  elems = 1 - (tile - 1) * rows;
            STEP_TC: elems = rows - (tile - 1);
            default: elems = 1 - (cols - 1) * rows;
         endcase
      end
      return elems * eb;
   endfunction

endpackage

// File: rtl/transpose_addr_gen_if.sv
// Address-pair stream from the generator to the memory read/write engine.
interface transpose_addr_gen_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [ADDR_WIDTH-1:0] dst_addr;
   logic                  last;

   modport master (output out_valid, src_addr, dst_addr, last, input out_ready);
   modport slave  (input out_valid, src_addr, dst_addr, last, output out_ready);
endinterface

// File: rtl/transpose_addr_gen_tile_counter.sv
// Nested wrap counter over (c, r, tc, tr); wrap[0]=c, [1]=r, [2]=tc, [3]=tr at maximum.
module tile_counter #(
   parameter int TILE   = 2,
   parameter int TC_NUM = 4,
   parameter int TR_NUM = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       adv,
   output logic [3:0] wrap
);

   localparam int TW  = (TILE   > 1) ? $clog2(TILE)   : 1;
   localparam int TCW = (TC_NUM > 1) ? $clog2(TC_NUM) : 1;
   localparam int TRW = (TR_NUM > 1) ? $clog2(TR_NUM) : 1;

   logic [TW-1:0]  c_cnt;
   logic [TW-1:0]  r_cnt;
   logic [TCW-1:0] tc_cnt;
   logic [TRW-1:0] tr_cnt;

   assign wrap[0] = (c_cnt  == TW'(TILE - 1));
   assign wrap[1] = (r_cnt  == TW'(TILE - 1));
   assign wrap[2] = (tc_cnt == TCW'(TC_NUM - 1));
   assign wrap[3] = (tr_cnt == TRW'(TR_NUM - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         c_cnt  <= '0;
         r_cnt  <= '0;
         tc_cnt <= '0;
         tr_cnt <= '0;
      end else if (adv) begin
         if (!wrap[0]) begin
            c_cnt <= c_cnt + TW'(1);
         end else begin
            c_cnt <= '0;
            if (!wrap[1]) begin
               r_cnt <= r_cnt + TW'(1);
            end else begin
               r_cnt <= '0;
               if (!wrap[2]) begin
                  tc_cnt <= tc_cnt + TCW'(1);
               end else begin
                  tc_cnt <= '0;
                  tr_cnt <= wrap[3] ? '0 : tr_cnt + TRW'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/transpose_addr_gen.sv
// Self-sequencing tiled transpose/copy address generator: one start, ROWS*COLS address pairs.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// RUN     | presenting address pairs, one per accepted handshake
// DONE    | one-cycle done pulse; start is dropped here
module transpose_addr_gen
   import transpose_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int TILE       = 2,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] src_base,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   transpose_addr_gen_if.master  strm,
   output logic                  busy,
   output logic                  done
);

   localparam int EB    = DATA_WIDTH / 8;
   localparam int BEATS = ROWS * COLS;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_DONE = ST_DONE;

   localparam logic [ADDR_WIDTH-1:0] SRC_C  = ADDR_WIDTH'(stride_bytes(STEP_C,  1'b0, ROWS, COLS, TILE, EB));
   localparam logic [ADDR_WIDTH-1:0] SRC_R  = ADDR_WIDTH'(stride_bytes(STEP_R,  1'b0, ROWS, COLS, TILE, EB));
   localparam logic [ADDR_WIDTH-1:0] SRC_TC = ADDR_WIDTH'(stride_bytes(STEP_TC, 1'b0, ROWS, COLS, TILE, EB));
   localparam logic [ADDR_WIDTH-1:0] SRC_TR = ADDR_WIDTH'(stride_bytes(STEP_TR, 1'b0, ROWS, COLS, TILE, EB));
   localparam logic [ADDR_WIDTH-1:0] TRN_C  = ADDR_WIDTH'(stride_bytes(STEP_C,  1'b1, ROWS, COLS, TILE, EB));
   localparam logic [ADDR_WIDTH-1:0] TRN_R  = ADDR_WIDTH'(stride_bytes(STEP_R,  1'b1, ROWS, COLS, TILE, EB));
   localparam logic [ADDR_WIDTH-1:0] TRN_TC = ADDR_WIDTH'(stride_bytes(STEP_TC, 1'b1, ROWS, COLS, TILE, EB));
   localparam logic [ADDR_WIDTH-1:0] TRN_TR = ADDR_WIDTH'(stride_bytes(STEP_TR, 1'b1, ROWS, COLS, TILE, EB));

   logic [1:0]            state;
   logic                  mode_q;
   logic [BW-1:0]         beats_left;
   logic [3:0]            wrap;
   logic                  fire;
   logic                  start_ok;
   step_e                 step;
   logic [ADDR_WIDTH-1:0] src_step;
   logic [ADDR_WIDTH-1:0] trn_step;
   logic [ADDR_WIDTH-1:0] dst_step;

   assign fire     = strm.out_valid && strm.out_ready;
   assign start_ok = (state == S_IDLE) && start;

   tile_counter #(
      .TILE   (TILE),
      .TC_NUM (COLS / TILE),
      .TR_NUM (ROWS / TILE)
   ) u_tile_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_ok),
      .adv   (fire && !strm.last),
      .wrap  (wrap)
   );

   always_comb begin
      step     = STEP_TR;
      src_step = SRC_TR;
      trn_step = TRN_TR;
      if (!wrap[0])      step = STEP_C;
      else if (!wrap[1]) step = STEP_R;
      else if (!wrap[2]) step = STEP_TC;
      case (step)
         STEP_C:  begin src_step = SRC_C;  trn_step = TRN_C;  end
         STEP_R:  begin src_step = SRC_R;  trn_step = TRN_R;  end
         STEP_TC: begin src_step = SRC_TC; trn_step = TRN_TC; end
         default: begin src_step = SRC_TR; trn_step = TRN_TR; end
      endcase
      dst_step = (mode_q == MODE_COPY) ? src_step : trn_step;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         mode_q         <= MODE_TRANSPOSE;
         beats_left     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         strm.out_valid <= 1'b0;
         strm.last      <= 1'b0;
         strm.src_addr  <= '0;
         strm.dst_addr  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_RUN;
                  mode_q         <= mode;
                  beats_left     <= BW'(BEATS - 1);
                  busy           <= 1'b1;
                  strm.out_valid <= 1'b1;
                  strm.last      <= (BEATS == 1);
                  strm.src_addr  <= src_base;
                  strm.dst_addr  <= dst_base;
               end
            end
            S_RUN: begin
               if (fire) begin
                  if (strm.last) begin
                     state          <= S_DONE;
                     busy           <= 1'b0;
                     done           <= 1'b1;
                     strm.out_valid <= 1'b0;
                     strm.last      <= 1'b0;
                  end else begin
                     beats_left    <= beats_left - BW'(1);
                     strm.last     <= (beats_left == BW'(1));
                     strm.src_addr <= strm.src_addr + src_step;
                     strm.dst_addr <= strm.dst_addr + dst_step;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
